// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache
// Hits are served combinationally; misses run WRITEBACK/FETCH/UPDATE against block memory.
module dcache_controller #(
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);
    localparam int TAG_BITS = 6 - INDEX_BITS;
    localparam int NBLK     = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t                state_q, state_d;
    logic                  first_q;
    logic [TAG_BITS-1:0]   req_tag_q;
    logic [INDEX_BITS-1:0] req_idx_q;
    logic [NBLK-1:0]       valid_q;
    logic [NBLK-1:0]       dirty_q;
    logic [31:0]           data_q [NBLK];
    logic [TAG_BITS-1:0]   tag_q  [NBLK];

    logic [TAG_BITS-1:0]   addr_tag;
    logic [INDEX_BITS-1:0] addr_idx;
    logic [1:0]            addr_off;
    logic                  access, hit, miss, wr_hit;

    assign addr_tag = ADDRESS[7 -: TAG_BITS];
    assign addr_idx = ADDRESS[OFFSET_BITS +: INDEX_BITS];
    assign addr_off = ADDRESS[1:0];
    assign access   = READ | WRITE;
    assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign miss     = (state_q == IDLE) && access && !hit;
    // READ wins when both strobes are high, so a combined request never stores
    assign wr_hit   = (state_q == IDLE) && WRITE && !READ && hit;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
        end
    end

    // A transfer state always spends its entry cycle before honouring MEM_BUSYWAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (miss) state_d = dirty_q[addr_idx] ? WRITEBACK : FETCH;
            WRITEBACK: if (!first_q && !MEM_BUSYWAIT) state_d = FETCH;
            FETCH:     if (!first_q && !MEM_BUSYWAIT) state_d = UPDATE;
            UPDATE:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        BUSYWAIT      = 1'b1;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 6'h00;
        MEM_WRITEDATA = 32'h0;
        READDATA      = 8'h00;
        case (state_q)
            IDLE: begin
                BUSYWAIT = RESET && access && !hit;
                if (RESET && hit) READDATA = data_q[addr_idx][{addr_off, 3'b000} +: 8];
            end
            WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[req_idx_q], req_idx_q};
                MEM_WRITEDATA = data_q[req_idx_q];
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {req_tag_q, req_idx_q};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q   <= '0;
            dirty_q   <= '0;
            req_tag_q <= '0;
            req_idx_q <= '0;
        end else begin
            if (miss) begin
                req_tag_q <= addr_tag;
                req_idx_q <= addr_idx;
            end
            if (wr_hit) dirty_q[addr_idx] <= 1'b1;
            if (state_q == UPDATE) begin
                valid_q[req_idx_q] <= 1'b1;
                dirty_q[req_idx_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_hit) begin
            data_q[addr_idx][{addr_off, 3'b000} +: 8] <= WRITEDATA;
        end else if (state_q == UPDATE) begin
            data_q[req_idx_q] <= MEM_READDATA;
            tag_q[req_idx_q]  <= req_tag_q;
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed self-checking bench for dcache_controller
module tb_dcache_controller;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA = 32'h0;
    logic        MEM_BUSYWAIT = 1'b0;

    int tests = 0;
    int fails = 0;

    dcache_controller dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #3;
        chk("rst_busywait", {31'h0, BUSYWAIT}, 32'h0);
        chk("rst_mem_read", {31'h0, MEM_READ}, 32'h0);
        chk("rst_mem_write", {31'h0, MEM_WRITE}, 32'h0);
        chk("rst_mem_addr", {26'h0, MEM_ADDRESS}, 32'h0);
        chk("rst_mem_wdata", MEM_WRITEDATA, 32'h0);
        chk("rst_readdata", {24'h0, READDATA}, 32'h0);
        tick();
        RESET = 1'b1;
        tick();

        // cold read miss on 0x05 -> FETCH of block 0x01
        READ = 1'b1; ADDRESS = 8'h05; #1;
        chk("miss_busy_same_cycle", {31'h0, BUSYWAIT}, 32'h1);
        chk("miss_idle_no_read", {31'h0, MEM_READ}, 32'h0);
        tick();
        chk("fetch1_mem_read", {31'h0, MEM_READ}, 32'h1);
        chk("fetch1_mem_write", {31'h0, MEM_WRITE}, 32'h0);
        chk("fetch1_addr", {26'h0, MEM_ADDRESS}, 32'h01);
        chk("fetch1_busy", {31'h0, BUSYWAIT}, 32'h1);
        MEM_READDATA = 32'hDDCCBBAA;
        tick();
        chk("fetch1_min2", {31'h0, MEM_READ}, 32'h1);
        tick();
        chk("update1_mem_read", {31'h0, MEM_READ}, 32'h0);
        chk("update1_busy", {31'h0, BUSYWAIT}, 32'h1);
        tick();
        chk("rd05_busy", {31'h0, BUSYWAIT}, 32'h0);
        chk("rd05_data", {24'h0, READDATA}, 32'hBB);
        chk("rd05_no_write", {31'h0, MEM_WRITE}, 32'h0);

        // same-block hit
        ADDRESS = 8'h07; #1;
        chk("rd07_busy", {31'h0, BUSYWAIT}, 32'h0);
        chk("rd07_data", {24'h0, READDATA}, 32'hDD);
        chk("rd07_no_strobe", {30'h0, MEM_READ, MEM_WRITE}, 32'h0);
        tick();

        // write hit, then read back
        READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h04; WRITEDATA = 8'h5A; #1;
        chk("wr04_busy", {31'h0, BUSYWAIT}, 32'h0);
        tick();
        WRITE = 1'b0; READ = 1'b1; #1;
        chk("rd04_data", {24'h0, READDATA}, 32'h5A);
        // READ and WRITE together: store must be ignored
        WRITE = 1'b1; WRITEDATA = 8'hFF; ADDRESS = 8'h06;
        tick();
        WRITE = 1'b0; #1;
        chk("rdwr_no_store", {24'h0, READDATA}, 32'hCC);
        tick();

        // conflict miss on dirty block: WRITEBACK then FETCH with stalled memory
        ADDRESS = 8'h24; #1;
        chk("rd24_busy", {31'h0, BUSYWAIT}, 32'h1);
        tick();
        chk("wb_mem_write", {31'h0, MEM_WRITE}, 32'h1);
        chk("wb_mem_read", {31'h0, MEM_READ}, 32'h0);
        chk("wb_addr", {26'h0, MEM_ADDRESS}, 32'h01);
        chk("wb_data", MEM_WRITEDATA, 32'hDDCCBB5A);
        chk("wb_busy", {31'h0, BUSYWAIT}, 32'h1);
        tick();
        chk("wb_min2", {31'h0, MEM_WRITE}, 32'h1);
        tick();
        chk("fetch2_mem_read", {31'h0, MEM_READ}, 32'h1);
        chk("fetch2_mem_write", {31'h0, MEM_WRITE}, 32'h0);
        chk("fetch2_addr", {26'h0, MEM_ADDRESS}, 32'h09);
        MEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fetch2_hold_read", {31'h0, MEM_READ}, 32'h1);
            chk("fetch2_hold_busy", {31'h0, BUSYWAIT}, 32'h1);
        end
        MEM_BUSYWAIT = 1'b0; MEM_READDATA = 32'h44332211;
        tick();
        chk("update2_mem_read", {31'h0, MEM_READ}, 32'h0);
        chk("update2_busy", {31'h0, BUSYWAIT}, 32'h1);
        tick();
        chk("rd24_hit_busy", {31'h0, BUSYWAIT}, 32'h0);
        chk("rd24_data", {24'h0, READDATA}, 32'h11);
        tick();

        // reset mid-FETCH: clean victim goes straight to FETCH
        ADDRESS = 8'h05;
        tick();
        chk("fetch3_mem_read", {31'h0, MEM_READ}, 32'h1);
        #2 RESET = 1'b0;
        #1;
        chk("rst_mid_mem_read", {31'h0, MEM_READ}, 32'h0);
        chk("rst_mid_busy", {31'h0, BUSYWAIT}, 32'h0);
        #2 RESET = 1'b1;
        ADDRESS = 8'h24; #1;
        chk("post_rst_miss", {31'h0, BUSYWAIT}, 32'h1);
        READ = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU datapath and the 32-bit-block data memory.
- The control unit's READ/WRITE strobes drive it, and its BUSYWAIT drives the control unit's BUSYWAIT/HOLD input, which stalls PC and register-file writes.
- Hits complete with no stall. Misses run a writeback/fetch FSM against the slow memory.

Parameters:
- INDEX_BITS, 3, log2 of block count (8 blocks of 4 bytes). TAG width = 6 - INDEX_BITS.
- OFFSET_BITS, 2, byte offset within a 32-bit block. Fixed; must stay 2.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU load request (lwd/lwi), held until BUSYWAIT low.
- WRITE  in  1  CPU store request (swd/swi), held until BUSYWAIT low.
- ADDRESS  in  8  CPU byte address: {tag, index, offset}.
- WRITEDATA  in  8  store byte.
- READDATA  out  8  load byte.
- BUSYWAIT  out  1  stall to CPU.
- MEM_READ  out  1  memory block read request.
- MEM_WRITE  out  1  memory block write request.
- MEM_ADDRESS  out  6  memory block address {tag, index}.
- MEM_WRITEDATA  out  32  block being written back.
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy.

Behaviour:
- Storage per block: 32-bit data, TAG, valid, dirty.
- On RESET low, asynchronously:
  - all valid and dirty bits cleared;
  - FSM goes to IDLE;
  - READDATA=0, BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - Data/tag arrays need no reset.
- hit = valid[index] && tag[index]==ADDRESS tag. Combinational (#1 tag-compare delay allowed in sim; no functional dependence on it).
- Access = READ|WRITE. If both are high, it is treated as READ; WRITE is ignored.
- IDLE:
  - BUSYWAIT = access && !hit, combinational, same cycle as the request.
  - Read hit: READDATA = byte[offset] of the indexed block, combinational; BUSYWAIT=0; the CPU samples at the next posedge.
  - Write hit: at the posedge, byte[offset] <= WRITEDATA and dirty <= 1. BUSYWAIT=0.
  - Miss with dirty victim -> WRITEBACK. Miss with clean or invalid victim -> FETCH.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=victim data, BUSYWAIT=1.
  - Exit on the first posedge where MEM_BUSYWAIT==0, excluding the entry cycle (minimum 2 cycles in state) -> FETCH.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS={ADDRESS tag, index}, BUSYWAIT=1.
  - Same exit rule as WRITEBACK -> UPDATE.
- UPDATE (1 cycle):
  - BUSYWAIT=1, memory strobes 0.
  - At the posedge: data <= MEM_READDATA, tag <= ADDRESS tag, valid <= 1, dirty <= 0. Then -> IDLE.
  - In IDLE the still-held request now hits. Read data follows the hit rule; a write sets dirty.
- MEM_READ and MEM_WRITE are never high simultaneously. Both are 0 in IDLE and UPDATE.
- The request must be held stable while BUSYWAIT=1. Changing ADDRESS mid-miss is illegal (undefined result); only the address latched at IDLE exit is used for MEM_ADDRESS in FETCH.
- Access dropped while in WRITEBACK/FETCH: the FSM completes the sequence anyway, keeping the cache consistent.
- RESET asserted mid-miss: strobes drop immediately and the in-flight transfer is abandoned. The memory model must tolerate this. The CPU reissues after reset.
- Byte order within a block: offset 0 = bits [7:0], offset 3 = bits [31:24].
- Miss latency, clean victim: 1 (FETCH) + memory latency + 1 (UPDATE). Dirty victim additionally includes the WRITEBACK time.

Test Plan:
- After reset, READ ADDRESS=8'h05 -> BUSYWAIT=1; MEM_READ=1 with MEM_ADDRESS=6'h01; memory returns 32'hDDCCBBAA -> UPDATE, then READDATA=8'hBB with BUSYWAIT=0; no MEM_WRITE.
- Following READ 8'h07 (same block) -> hit, BUSYWAIT stays 0, READDATA=8'hDD, no memory strobes.
- WRITE 8'h04 data 8'h5A on the cached block -> no stall; next READ 8'h04 returns 8'h5A; dirty set.
- READ 8'h24 (index 1, tag 1, conflicts with the dirty block):
  - first MEM_WRITE=1, MEM_ADDRESS=6'h01, MEM_WRITEDATA=32'hDDCCBB5A;
  - then MEM_READ=1, MEM_ADDRESS=6'h09;
  - BUSYWAIT=1 throughout, then the hit completes.
- MEM_BUSYWAIT held high for 5 cycles in FETCH -> MEM_READ stays 1 and BUSYWAIT stays 1 the whole time; advance only on the posedge where MEM_BUSYWAIT=0.
- RESET pulsed low mid-FETCH -> MEM_READ=0 and BUSYWAIT=0 without a clock edge; a subsequent READ of the same address misses (valid cleared).
